// File: rtl/sba_redirect.sv
// -----------------------------------------------------------------------------
// sba_redirect
// Single-entry pipeline stage that sits after execute and repairs branch
// mispredictions. It holds one instruction. When a risky branch leaves the
// stage, the module latches the corrected target and checkpoint. It then waits
// for the delay-slot instruction to leave. After that it spends exactly one
// cycle in REDIRECT, pulsing SBA_flush_w_o and discarding whatever it holds.
//
// Optional feature (macro SBA_PERF_CNT_EN): adds output SBA_mispredCnt_o, a
// 32-bit wrapping count of IDLE->WAIT_DS transitions.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   EXE_up_valid_w_i             upstream instruction offered
//   SBA_allowin_w_o              stage accepts upstream instruction this cycle
//   SBA_down_allowin_w_i         downstream accepts held instruction
//   EXE_up_VAddr_i/aluRes_i/corrDest_i   PC, result, resolved target
//   EXE_up_writeNum_i/corrTake_i/branchRisk_i/checkPoint_i  remaining fields
//   CP0_excOccur_w_i             exception kill, wins over everything but reset
//   SBA_valid_w_o, SBA_VAddr_o, SBA_aluRes_o, SBA_writeNum_o  held instruction
//   SBA_flush_w_o, SBA_redirectDest_o, SBA_checkPoint_o       repair outputs
// -----------------------------------------------------------------------------
module sba_redirect #(
    parameter int CKPT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EXE_up_valid_w_i,
    output logic              SBA_allowin_w_o,
    input  logic              SBA_down_allowin_w_i,
    input  logic [31:0]       EXE_up_VAddr_i,
    input  logic [31:0]       EXE_up_aluRes_i,
    input  logic [31:0]       EXE_up_corrDest_i,
    input  logic [4:0]        EXE_up_writeNum_i,
    input  logic              EXE_up_corrTake_i,
    input  logic              EXE_up_branchRisk_i,
    input  logic [CKPT_W-1:0] EXE_up_checkPoint_i,
    input  logic              CP0_excOccur_w_i,
    output logic              SBA_valid_w_o,
    output logic [31:0]       SBA_VAddr_o,
    output logic [31:0]       SBA_aluRes_o,
    output logic [4:0]        SBA_writeNum_o,
    output logic              SBA_flush_w_o,
    output logic [31:0]       SBA_redirectDest_o,
    output logic [CKPT_W-1:0] SBA_checkPoint_o
`ifdef SBA_PERF_CNT_EN
    ,
    output logic [31:0]       SBA_mispredCnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_has_data;
    logic [31:0]         r_vaddr;
    logic [31:0]         r_alu_res;
    logic [31:0]         r_corr_dest;
    logic [4:0]          r_write_num;
    logic                r_corr_take;
    logic                r_branch_risk;
    logic [CKPT_W-1:0]   r_check_point;

    logic [31:0]         r_redirect_dest;
    logic [CKPT_W-1:0]   r_redirect_ckpt;

    logic                w_redirect;
    logic                w_valid;
    logic                w_allowin;
    logic                w_handoff;
    logic                w_capture;
    logic                w_enter_wait;
    logic [31:0]         w_fix_dest;
    logic                w_flush;

    // Handshake terms shared by the FSM and the datapath
    always_comb begin
        w_redirect = (r_state == ST_REDIRECT);
        w_valid    = r_has_data && !w_redirect;
        w_allowin  = (!r_has_data || SBA_down_allowin_w_i) && !w_redirect;
        w_handoff  = w_valid && SBA_down_allowin_w_i;
        // An exception kills the incoming instruction as well as the held one
        w_capture  = EXE_up_valid_w_i && w_allowin && !CP0_excOccur_w_i;
        // Not-taken target skips the branch and its delay slot; wraps at 2^32
        w_fix_dest = r_corr_take ? r_corr_dest : (r_vaddr + 32'd8);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; an exception overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (CP0_excOccur_w_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_handoff && r_branch_risk) begin
                        w_state_nxt = ST_WAIT_DS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                // The delay slot leaves regardless of its own branchRisk
                ST_WAIT_DS: begin
                    if (w_handoff) begin
                        w_state_nxt = ST_REDIRECT;
                    end else begin
                        w_state_nxt = ST_WAIT_DS;
                    end
                end
                ST_REDIRECT: w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM output logic. A reset or an exception in the REDIRECT cycle
    // abandons the repair, so neither may see a flush pulse.
    always_comb begin
        w_enter_wait = (r_state == ST_IDLE) && (w_state_nxt == ST_WAIT_DS);
        w_flush      = w_redirect && !CP0_excOccur_w_i && !rst;
    end

    // Occupancy flag: the REDIRECT cycle and exceptions discard the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_has_data <= 1'b0;
        end else if (CP0_excOccur_w_i || w_redirect) begin
            r_has_data <= 1'b0;
        end else if (w_capture) begin
            r_has_data <= 1'b1;
        end else if (w_handoff) begin
            r_has_data <= 1'b0;
        end
    end

    // Instruction payload register, loaded on capture only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vaddr       <= 32'd0;
            r_alu_res     <= 32'd0;
            r_corr_dest   <= 32'd0;
            r_write_num   <= 5'd0;
            r_corr_take   <= 1'b0;
            r_branch_risk <= 1'b0;
            r_check_point <= {CKPT_W{1'b0}};
        end else if (w_capture) begin
            r_vaddr       <= EXE_up_VAddr_i;
            r_alu_res     <= EXE_up_aluRes_i;
            r_corr_dest   <= EXE_up_corrDest_i;
            r_write_num   <= EXE_up_writeNum_i;
            r_corr_take   <= EXE_up_corrTake_i;
            r_branch_risk <= EXE_up_branchRisk_i;
            r_check_point <= EXE_up_checkPoint_i;
        end
    end

    // Repair target latched when the mispredicted branch leaves the stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_dest <= 32'd0;
            r_redirect_ckpt <= {CKPT_W{1'b0}};
        end else if (w_enter_wait) begin
            r_redirect_dest <= w_fix_dest;
            r_redirect_ckpt <= r_check_point;
        end
    end

`ifdef SBA_PERF_CNT_EN
    logic [31:0] r_mispred_cnt;

    // Misprediction counter; natural 32-bit wrap, never cleared by exceptions
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispred_cnt <= 32'd0;
        end else if (w_enter_wait) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign SBA_mispredCnt_o = r_mispred_cnt;
`endif

    assign SBA_allowin_w_o    = w_allowin;
    assign SBA_valid_w_o      = w_valid;
    assign SBA_VAddr_o        = r_vaddr;
    assign SBA_aluRes_o       = r_alu_res;
    assign SBA_writeNum_o     = r_write_num;
    assign SBA_flush_w_o      = w_flush;
    assign SBA_redirectDest_o = r_redirect_dest;
    assign SBA_checkPoint_o   = r_redirect_ckpt;

endmodule

// File: doc/sba_redirect.md
SBA_REDIRECT -- requirements
Module: sba_redirect

Interface
REQ-001 SHALL have parameter CKPT_W, default 8, width of the branch checkpoint field.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port EXE_up_valid_w_i  input  1  upstream instruction offered.
REQ-005 SHALL have port SBA_allowin_w_o  output  1  stage accepts an upstream instruction this cycle.
REQ-006 SHALL have port SBA_down_allowin_w_i  input  1  downstream accepts this stage's instruction.
REQ-007 SHALL have ports EXE_up_VAddr_i, EXE_up_aluRes_i, EXE_up_corrDest_i  input  32 each  PC, result and resolved target.
REQ-008 SHALL have ports EXE_up_writeNum_i  input  5, EXE_up_corrTake_i  input  1, EXE_up_branchRisk_i  input  1, EXE_up_checkPoint_i  input  CKPT_W.
REQ-009 SHALL have port CP0_excOccur_w_i  input  1  exception kill.
REQ-010 SHALL have ports SBA_valid_w_o  output  1, SBA_VAddr_o  output  32, SBA_aluRes_o  output  32, SBA_writeNum_o  output  5  held instruction.
REQ-011 SHALL have ports SBA_flush_w_o  output  1, SBA_redirectDest_o  output  32, SBA_checkPoint_o  output  CKPT_W  misprediction repair.

Function
REQ-012 SHALL hold one instruction in a register with flag hasData; SBA_allowin_w_o = (!hasData || SBA_down_allowin_w_i) && state!=REDIRECT.
REQ-013 SHALL capture all EXE_up_* fields when EXE_up_valid_w_i && SBA_allowin_w_o; a handoff occurs when SBA_valid_w_o && SBA_down_allowin_w_i.
REQ-014 SHALL drive SBA_valid_w_o = hasData && state!=REDIRECT; data outputs come directly from the register (zero combinational latency).
REQ-015 SHALL clear hasData on a handoff with no simultaneous capture.
REQ-016 SHALL implement FSM IDLE, WAIT_DS, REDIRECT.
REQ-017 IDLE->WAIT_DS on handoff of an instruction with branchRisk=1; latch dest = corrTake ? corrDest : VAddr+8 (mod 2^32) and checkPoint.
REQ-018 WAIT_DS->REDIRECT on the next handoff (delay slot); branchRisk of that instruction SHALL be ignored.
REQ-019 REDIRECT SHALL last exactly one cycle: SBA_flush_w_o=1, outputs latched dest/checkpoint, hasData cleared, no capture; then IDLE.
REQ-020 SBA_flush_w_o SHALL be 0 in IDLE and WAIT_DS; SBA_redirectDest_o and SBA_checkPoint_o hold last latched values.
REQ-021 CP0_excOccur_w_i=1 SHALL, in any state, force IDLE, clear hasData, suppress capture and suppress SBA_flush_w_o that cycle (exception wins over redirect).
REQ-022 A handoff and a capture in the same cycle SHALL keep hasData=1 with new contents.

Reset
REQ-023 rst=1 at a rising edge SHALL set state=IDLE, hasData=0, all data/latched registers 0, counter 0, overriding any other input.
REQ-024 Outputs after reset: SBA_valid_w_o=0, SBA_flush_w_o=0, SBA_allowin_w_o=1, all buses 0.
REQ-025 Reset during WAIT_DS or REDIRECT SHALL abandon the pending redirect with no flush pulse.

Configuration
REQ-026 Macro SBA_PERF_CNT_EN: when defined, port SBA_mispredCnt_o output 32 SHALL exist, incrementing by 1 on each IDLE->WAIT_DS transition, wrapping 0xFFFFFFFF->0, unaffected by CP0_excOccur_w_i; when undefined, port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-027 Branch VAddr=0x1000, branchRisk=1, corrTake=1, corrDest=0x2000, then delay slot, both accepted -> flush pulse one cycle after delay-slot handoff, redirectDest=0x2000.
REQ-028 Branch VAddr=0xFFFFFFFC, risk=1, corrTake=0 -> redirectDest=0x00000004 after delay slot.
REQ-029 Hold SBA_down_allowin_w_i=0 for 3 cycles with hasData=1 -> SBA_allowin_w_o=0, outputs stable; release -> handoff and capture same cycle.
REQ-030 CP0_excOccur_w_i=1 in WAIT_DS -> state IDLE, SBA_valid_w_o=0 next cycle, no flush pulse ever.
REQ-031 rst=1 during REDIRECT-bound sequence -> no flush, outputs at reset values next cycle.
REQ-032 With SBA_PERF_CNT_EN, 3 mispredictions -> SBA_mispredCnt_o=3; preload 0xFFFFFFFF then one more -> 0.
